// File: rtl/ppm_encoder.sv
// PPM frame encoder: NUM_CH separator/slot pairs, a final separator, then a sync gap.
// Define PPM_FAILSAFE_EN to reload default channel values after 10 frame starts with no ch_valid.
module ppm_encoder #(
  parameter int NUM_CH      = 8,
  parameter int CLK_DIV     = 50,
  parameter int FRAME_US    = 22500,
  parameter int SEP_US      = 300,
  parameter int MIN_SYNC_US = 4000
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   en,
  input  logic [NUM_CH*10-1:0]   ch_in,
  input  logic                   ch_valid,
  output logic                   ppm,
  output logic                   frame_start,
  output logic                   busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int US_W  = 20;
  localparam int IDX_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, SEP, CHAN, SYNC} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [US_W-1:0]  us_cnt;
  logic [US_W-1:0]  elapsed;
  logic [IDX_W-1:0] idx;
  logic [9:0]       pending [NUM_CH];
  logic [9:0]       active  [NUM_CH];

  logic [9:0]       cur_val;
  logic [US_W-1:0]  target;
  logic             tick;
  logic             done;
  logic             start;

`ifdef PPM_FAILSAFE_EN
  logic [3:0]       fs_cnt;
  logic             fs_trip;
  assign fs_trip = (fs_cnt >= 4'd10);
`endif

  function automatic logic [9:0] clamp999(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  // Channel 2 is throttle and defaults to zero; every other channel to mid-stick.
  function automatic logic [9:0] rst_val(input int k);
    return (k == 2) ? 10'd0 : 10'd500;
  endfunction

  function automatic logic [US_W-1:0] sync_len(input logic [US_W-1:0] el);
    logic [US_W-1:0] fr;
    logic [US_W-1:0] ms;
    fr = US_W'(FRAME_US);
    ms = US_W'(MIN_SYNC_US);
    if (el >= fr || (fr - el) < ms) return ms;
    return fr - el;
  endfunction

  always_comb begin
    cur_val = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (idx == IDX_W'(k)) cur_val = active[k];
  end

  // Slot width is 1000+value us, of which the separator takes SEP_US.
  always_comb begin
    target = '0;
    case (state)
      SEP:     target = US_W'(SEP_US);
      CHAN:    target = US_W'(1000 - SEP_US) + US_W'(cur_val);
      SYNC:    target = sync_len(elapsed);
      default: target = '0;
    endcase
  end

  assign tick  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done  = tick && (us_cnt == target - 1'b1);
  assign start = en && ((state == IDLE) || (state == SYNC && done));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      div_cnt     <= '0;
      us_cnt      <= '0;
      elapsed     <= '0;
      idx         <= '0;
      ppm         <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        pending[k] <= rst_val(k);
        active[k]  <= rst_val(k);
      end
`ifdef PPM_FAILSAFE_EN
      fs_cnt      <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      if (start) begin
        state       <= SEP;
        ppm         <= 1'b0;
        frame_start <= 1'b1;
        busy        <= 1'b1;
        idx         <= '0;
        elapsed     <= '0;
        div_cnt     <= '0;
        us_cnt      <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
`ifdef PPM_FAILSAFE_EN
          if (fs_trip) begin
            pending[k] <= rst_val(k);
            active[k]  <= rst_val(k);
          end else begin
            active[k]  <= pending[k];
          end
`else
          active[k] <= pending[k];
`endif
        end
`ifdef PPM_FAILSAFE_EN
        if (!fs_trip) fs_cnt <= fs_cnt + 1'b1;
`endif
      end else if (state != IDLE) begin
        // Elapsed stays frozen during SYNC so the sync length is stable.
        if (tick && state != SYNC) elapsed <= elapsed + 1'b1;
        if (done) begin
          div_cnt <= '0;
          us_cnt  <= '0;
          case (state)
            SEP: begin
              ppm   <= 1'b1;
              state <= (idx < IDX_W'(NUM_CH)) ? CHAN : SYNC;
            end
            CHAN: begin
              ppm   <= 1'b0;
              state <= SEP;
              idx   <= idx + 1'b1;
            end
            default: begin
              ppm   <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end else begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) us_cnt <= us_cnt + 1'b1;
        end
      end

      // Capture after the frame copy so a same-cycle strobe only reaches the next frame.
      if (ch_valid) begin
        for (int k = 0; k < NUM_CH; k++)
          pending[k] <= clamp999(ch_in[10*k +: 10]);
`ifdef PPM_FAILSAFE_EN
        fs_cnt <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ppm_encoder.sv
// Scoreboard bench for ppm_encoder: a slot-level frame model predicts every ppm run.
module tb_ppm_encoder;

  localparam int N  = 3;
  localparam int D  = 2;
  localparam int FR = 5000;
  localparam int SP = 300;
  localparam int MS = 500;
  localparam int K  = 5;

  logic           clk = 1'b0;
  logic           RST = 1'b1;
  logic           en = 1'b0;
  logic [N*10-1:0] ch_in = '0;
  logic           ch_valid = 1'b0;
  logic           ppm;
  logic           frame_start;
  logic           busy;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic lvl;
    int   len;
    logic fs;
  } run_t;

  run_t            exp_q[$];
  int              ev_edge[$];
  logic [N*10-1:0] ev_val[$];
  int              en_drop_edge;
  int              busy_fall_exp;
  bit              mon_en = 0;
  bit              busy_fell = 0;

  ppm_encoder #(
    .NUM_CH(N), .CLK_DIV(D), .FRAME_US(FR), .SEP_US(SP), .MIN_SYNC_US(MS)
  ) dut (
    .clk(clk), .RST(RST), .en(en), .ch_in(ch_in), .ch_valid(ch_valid),
    .ppm(ppm), .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [N*10-1:0] rand_vals();
    logic [N*10-1:0] v;
    for (int k = 0; k < N; k++) v[10*k +: 10] = 10'($urandom_range(0, 1023));
    return v;
  endfunction

  task automatic push_run(input logic lvl, input int len_us, input logic fs);
    run_t r;
    r.lvl = lvl; r.len = len_us * D; r.fs = fs;
    exp_q.push_back(r);
  endtask

  // Frame = N slots of (1000+value) us each opened by a separator, a closing separator,
  // then a sync gap filling the frame to FR us but never shorter than MS us.
  task automatic build_model(input int f0);
    int f, ptr, len, slots_us, sync_us, rnd;
    int v[N];
    logic [N*10-1:0] pend, a;
    for (int k = 0; k < N; k++) pend[10*k +: 10] = (k == 2) ? 10'd0 : 10'd500;
    f = f0; ptr = 0;
    for (int i = 0; i < K; i++) begin
      while (ptr < ev_edge.size() && ev_edge[ptr] < f) begin
        pend = ev_val[ptr];
        ptr++;
      end
      slots_us = 0;
      for (int k = 0; k < N; k++) begin
        v[k] = int'(pend[10*k +: 10]);
        if (v[k] > 999) v[k] = 999;
        slots_us += 1000 + v[k];
      end
      sync_us = FR - (slots_us + SP);
      if (sync_us < MS) sync_us = MS;
      len = (slots_us + SP + sync_us) * D;
      for (int k = 0; k < N; k++) begin
        push_run(1'b0, SP, k == 0);
        push_run(1'b1, 1000 + v[k] - SP, 1'b0);
      end
      push_run(1'b0, SP, 1'b0);
      if (i != K - 1) push_run(1'b1, sync_us, 1'b0);
      case (i)
        0: begin
          a = {N{10'd999}};
          a[19:10] = 10'd1023;
          ev_edge.push_back(f); ev_val.push_back(a);
        end
        1: begin
          rnd = int'($urandom_range(1, len - 1));
          ev_edge.push_back(f + rnd); ev_val.push_back(rand_vals());
        end
        2: begin
          rnd = int'($urandom_range(1, len - 1));
          ev_edge.push_back(f + rnd); ev_val.push_back(rand_vals());
          ev_edge.push_back(f + len); ev_val.push_back(rand_vals());
        end
        default: ;
      endcase
      if (i == K - 1) begin
        en_drop_edge  = f + int'($urandom_range(1, len - 1));
        busy_fall_exp = f + len;
      end
      f += len;
    end
  endtask

  // Monitor: measures each ppm run at the falling edge and pops the scoreboard.
  initial begin
    logic prev, rfs, pb;
    int   rl, nrun;
    bit   armed;
    run_t r;
    prev = 1'b1; rfs = 1'b0; pb = 1'b0; rl = 0; nrun = 0; armed = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        armed = 0;
        pb = busy;
        continue;
      end
      if (!armed) begin
        if (ppm == 1'b0) begin
          armed = 1; prev = 1'b0; rl = 1; rfs = frame_start;
        end
      end else if (ppm !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_run: level %0d len %0d arrived but none expected", prev, rl);
        end else begin
          r = exp_q.pop_front();
          if (r.lvl !== prev || r.len != rl || r.fs !== rfs) begin
            errors++;
            $display("FAIL run_%0d: got level %0d len %0d fs %0d, expected level %0d len %0d fs %0d",
                     nrun, prev, rl, rfs, r.lvl, r.len, r.fs);
          end
        end
        nrun++;
        prev = ppm; rl = 1; rfs = frame_start;
      end else begin
        rl++;
      end
      if (pb && !busy) begin
        chk("busy_fall_cycle", cyc, busy_fall_exp);
        busy_fell = 1;
      end
      pb = busy;
    end
  end

  task automatic meas(input logic lvl, output int len);
    len = 0;
    while (ppm === lvl && len < 20000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_fs(output bit ok);
    ok = 0;
    for (int n = 0; n < 40000; n++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int s, ptr, l;
    bit ok;

    repeat (3) @(negedge clk);
    chk("reset_ppm", ppm, 1);
    chk("reset_busy", busy, 0);
    chk("reset_frame_start", frame_start, 0);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_en_busy", busy, 0);
    chk("reset_en_ppm", ppm, 1);
    en = 1'b0;
    RST = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_ppm", ppm, 1);
    chk("idle_busy", busy, 0);

    mon_en = 1;
    @(negedge clk);
    s = cyc;
    en = 1'b1;
    build_model(s + 1);
    ptr = 0;
    while (cyc < busy_fall_exp + 20) begin
      if (ptr < ev_edge.size() && ev_edge[ptr] == cyc + 1) begin
        ch_valid = 1'b1;
        ch_in = ev_val[ptr];
        ptr++;
      end else begin
        ch_valid = 1'b0;
        ch_in = rand_vals();
      end
      if (cyc + 1 == en_drop_edge) en = 1'b0;
      @(negedge clk);
    end
    ch_valid = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("busy_fell", busy_fell, 1);
    chk("final_idle_ppm", ppm, 1);
    mon_en = 0;

    en = 1'b1;
    wait_fs(ok);
    chk("restart_frame_start", ok, 1);
    repeat (100) @(negedge clk);
    chk("pre_abort_low", ppm, 0);
    #2 RST = 1'b1;
    #1;
    chk("abort_ppm_async", ppm, 1);
    chk("abort_busy_async", busy, 0);
    @(negedge clk);
    RST = 1'b0;
    wait_fs(ok);
    chk("post_reset_frame_start", ok, 1);
    meas(1'b0, l); chk("post_reset_sep0", l, SP * D);
    meas(1'b1, l); chk("post_reset_ch0_high", l, (1000 + 500 - SP) * D);
    meas(1'b0, l); chk("post_reset_sep1", l, SP * D);
    meas(1'b1, l); chk("post_reset_ch1_high", l, (1000 + 500 - SP) * D);
    meas(1'b0, l); chk("post_reset_sep2", l, SP * D);
    meas(1'b1, l); chk("post_reset_ch2_high", l, (1000 + 0 - SP) * D);
    meas(1'b0, l); chk("post_reset_sep_final", l, SP * D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
